// File: rtl/audio_frame_sequencer_pkg.sv
// Shared constants and types for the audio frame sequencer.
// Defaults target an I2S transmitter at about 48 kHz from a 50 MHz clock.
package audio_pkg;

    localparam int AUDIO_SIZE       = 8;
    localparam int FRAME_CYCLES_48K = 1042;
    localparam int FIFO_DEPTH       = 4;

    typedef struct packed {
        logic [AUDIO_SIZE-1:0] left;
        logic [AUDIO_SIZE-1:0] right;
    } stereo_sample_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_frame_sequencer_if.sv
// Upstream sample handshake plus frame-timed outputs to the I2S transmitter.
// master = sample source / observer, slave = sequencer.
interface audio_frame_sequencer_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [SIZE-1:0] in_left;
    logic [SIZE-1:0] in_right;
    logic            in_valid;
    logic            in_ready;
    logic            mute;
    logic            ws;
    logic [SIZE-1:0] data_left;
    logic [SIZE-1:0] data_right;
    logic            frame_strobe;
    logic [FW-1:0]   fill;
    logic [7:0]      underruns;

    modport master (
        output in_left, in_right, in_valid, mute,
        input  in_ready, ws, data_left, data_right,
        input  frame_strobe, fill, underruns
    );

    modport slave (
        input  in_left, in_right, in_valid, mute,
        output in_ready, ws, data_left, data_right,
        output frame_strobe, fill, underruns
    );

endinterface

// File: rtl/audio_frame_sequencer_fifo.sv
// Circular sample FIFO; push is ignored when full, pop when empty.
// Storage is not reset, only pointers and the occupancy count.
module sample_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH) + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [FW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_data;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Frame timing for an I2S transmitter: buffers stereo samples and
// releases one frame per FRAME_CYCLES with word select and underrun count.
module audio_frame_sequencer
    import audio_pkg::*;
#(
    parameter int SIZE         = AUDIO_SIZE,
    parameter int FRAME_CYCLES = FRAME_CYCLES_48K,
    parameter int DEPTH        = FIFO_DEPTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    audio_frame_sequencer_if.slave  io_bus
);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     r_cnt;
    logic              r_ws;
    logic              r_strobe;
    logic [SIZE-1:0]   r_left;
    logic [SIZE-1:0]   r_right;
    logic [7:0]        r_underruns;

    logic [CW-1:0]     w_cnt_nxt;
    logic              w_boundary;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FW-1:0]     w_count;
    logic [2*SIZE-1:0] w_head;

    assign w_boundary = (r_cnt == CW'(FRAME_CYCLES - 1));
    assign w_cnt_nxt  = w_boundary ? '0 : r_cnt + 1'b1;

    // Occupancy before any same-edge pop decides acceptance.
    assign w_push = io_bus.in_valid && !w_full;
    assign w_pop  = w_boundary && !w_empty;

    sample_fifo #(
        .W     (2 * SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({io_bus.in_left, io_bus.in_right}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_ws        <= 1'b0;
            r_strobe    <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_underruns <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ws     <= (w_cnt_nxt >= CW'(FRAME_CYCLES / 2));
            r_strobe <= w_boundary;
            if (w_boundary) begin
                if (!w_empty) begin
                    r_left  <= io_bus.mute ? '0 : w_head[2*SIZE-1:SIZE];
                    r_right <= io_bus.mute ? '0 : w_head[SIZE-1:0];
                end else begin
                    r_left      <= '0;
                    r_right     <= '0;
                    r_underruns <= sat_inc8(r_underruns);
                end
            end
        end
    end

    assign io_bus.in_ready     = !w_full;
    assign io_bus.ws           = r_ws;
    assign io_bus.frame_strobe = r_strobe;
    assign io_bus.data_left    = r_left;
    assign io_bus.data_right   = r_right;
    assign io_bus.fill         = w_count;
    assign io_bus.underruns    = r_underruns;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed and random bench for audio_frame_sequencer against a
// queue-based frame model.
module tb_audio_frame_sequencer;
    import audio_pkg::*;

    localparam int FC  = 8;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_frame_sequencer_if #(.SIZE(8), .DEPTH(DEP)) bus ();

    audio_frame_sequencer #(
        .SIZE         (8),
        .FRAME_CYCLES (FC),
        .DEPTH        (DEP)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    stereo_sample_t q[$];
    int         mcyc;
    logic [7:0] mdl, mdr;
    int         mund;
    bit         mws, mstb, m_pushed;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ws", bus.ws, mws);
        chk("strobe", bus.frame_strobe, mstb);
        chk("data_left", bus.data_left, mdl);
        chk("data_right", bus.data_right, mdr);
        chk("fill", bus.fill, q.size());
        chk("in_ready", bus.in_ready, q.size() < DEP);
        chk("underruns", bus.underruns, mund);
    endtask

    task automatic model_reset();
        q.delete();
        mcyc = 0;
        mdl = 0;
        mdr = 0;
        mund = 0;
        mws = 0;
        mstb = 0;
        m_pushed = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] l,
                        input logic [7:0] r, input bit m);
        bit bnd, pu, po;
        stereo_sample_t s, h;
        bus.in_valid = v;
        bus.in_left  = l;
        bus.in_right = r;
        bus.mute     = m;
        @(posedge clk);
        bnd = (mcyc % FC) == FC - 1;
        pu  = v && (q.size() < DEP);
        po  = bnd && (q.size() > 0);
        if (bnd) begin
            if (po) begin
                h   = q.pop_front();
                mdl = m ? 8'h00 : h.left;
                mdr = m ? 8'h00 : h.right;
            end else begin
                mdl = 0;
                mdr = 0;
                if (mund < 255) mund++;
            end
        end
        if (pu) begin
            s.left  = l;
            s.right = r;
            q.push_back(s);
        end
        m_pushed = pu;
        mcyc++;
        mws  = (mcyc % FC) >= FC / 2;
        mstb = bnd;
        #1;
        check_all();
    endtask

    task automatic to_boundary(input bit m);
        int n = 0;
        do begin
            step(0, 8'h00, 8'h00, m);
            n++;
        end while (!mstb && n < 20);
        chk("boundary_timeout", mstb, 1);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_left  = 0;
        bus.in_right = 0;
        bus.mute     = 0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 0;

        // Idle frame: ws pattern, strobe, first underrun
        repeat (8) step(0, 8'h00, 8'h00, 0);
        chk("first_underrun", bus.underruns, 1);
        chk("first_strobe", bus.frame_strobe, 1);

        // Two frames queued before a boundary
        step(1, 8'h11, 8'h22, 0);
        step(1, 8'h33, 8'h44, 0);
        chk("fill_two", bus.fill, 2);
        repeat (6) step(0, 8'h00, 8'h00, 0);
        chk("f1_left", bus.data_left, 8'h11);
        chk("f1_right", bus.data_right, 8'h22);
        chk("fill_one", bus.fill, 1);
        repeat (8) step(0, 8'h00, 8'h00, 0);
        chk("f2_left", bus.data_left, 8'h33);
        chk("f2_right", bus.data_right, 8'h44);
        chk("fill_zero", bus.fill, 0);
        repeat (8) step(0, 8'h00, 8'h00, 0);

        // Five frames against a depth-4 FIFO
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            do begin
                step(1, 8'hA0 + 8'(k), 8'hB0 + 8'(k), 0);
                n++;
            end while (!m_pushed && n < 40);
            chk("push_timeout", m_pushed, 1);
            if (k == 3) chk("full_not_ready", bus.in_ready, 0);
        end
        repeat (48) step(0, 8'h00, 8'h00, 0);

        // Mute applied to one queued frame
        to_boundary(0);
        step(1, 8'h7F, 8'h80, 0);
        step(1, 8'h55, 8'h66, 1);
        to_boundary(1);
        chk("mute_left", bus.data_left, 0);
        chk("mute_right", bus.data_right, 0);
        chk("mute_fill", bus.fill, 1);
        to_boundary(0);
        chk("unmute_left", bus.data_left, 8'h55);
        chk("unmute_right", bus.data_right, 8'h66);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 7) == 0);
        repeat (40) step(0, 8'h00, 8'h00, 0);

        // Reset mid-frame with three frames queued
        to_boundary(0);
        step(1, 8'h01, 8'h02, 0);
        step(1, 8'h03, 8'h04, 0);
        step(1, 8'h05, 8'h06, 0);
        step(0, 8'h00, 8'h00, 0);
        chk("pre_reset_fill", bus.fill, 3);
        #3;
        rst = 1;
        #1;
        model_reset();
        check_all();
        chk("reset_fill", bus.fill, 0);
        @(posedge clk);
        #1;
        check_all();
        rst = 0;
        repeat (24) step(0, 8'h00, 8'h00, 0);
        chk("post_reset_underruns", bus.underruns, 3);

        // Saturating underrun counter
        repeat (300 * FC) step(0, 8'h00, 8'h00, 0);
        chk("underrun_sat", bus.underruns, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_frame_sequencer.md
AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 8: sample width in bits; matches the I2S transmitter SIZE.
REQ-002 SHALL have parameter FRAME_CYCLES, default 1042: Clk cycles per stereo frame (about 48 kHz at 50 MHz); even, at least 4.
REQ-003 SHALL have parameter DEPTH, default 4: sample FIFO depth in frames; power of two.
REQ-004 Clk  input  1  system clock (MAX10_CLK1_50).
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 in_left  input  SIZE  left sample from the upstream source.
REQ-007 in_right  input  SIZE  right sample from the upstream source.
REQ-008 in_valid  input  1  upstream offers {in_left, in_right}.
REQ-009 in_ready  output  1  FIFO can accept a frame.
REQ-010 mute  input  1  forces silence on the outputs; FIFO still drains.
REQ-011 ws  output  1  word select to the I2S transmitter: 0 = left half, 1 = right half.
REQ-012 data_left  output  SIZE  left sample held for the current frame.
REQ-013 data_right  output  SIZE  right sample held for the current frame.
REQ-014 frame_strobe  output  1  one-cycle pulse on each frame boundary.
REQ-015 fill  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 underruns  output  8  saturating count of frames that started with an empty FIFO.

Function
REQ-017 Frame counter cnt SHALL run 0..FRAME_CYCLES-1, increment every Clk and wrap to 0.
REQ-018 ws SHALL be registered and equal 1 exactly while cnt >= FRAME_CYCLES/2; ws falls on the same edge cnt wraps to 0.
REQ-019 Frame boundary = the edge on which cnt goes from FRAME_CYCLES-1 to 0.
REQ-020 frame_strobe SHALL be 1 in the cycle following each frame boundary (cnt==0) and 0 otherwise.
REQ-021 Push SHALL occur on an edge where in_valid && in_ready; in_ready = (fill < DEPTH).
REQ-022 in_ready SHALL be computed from fill before any same-cycle pop; when full, no push occurs even if a pop happens on that edge.
REQ-023 On a frame boundary with fill > 0: pop the head; data_left/data_right SHALL load the popped samples, or 0 if mute=1.
REQ-024 On a frame boundary with fill == 0: data_left/data_right SHALL load 0 and underruns SHALL increment, saturating at 255.
REQ-025 data_left/data_right SHALL change only on frame boundaries and stay stable for the whole frame.
REQ-026 A simultaneous push and pop on a non-full FIFO SHALL leave fill unchanged and preserve FIFO order.
REQ-027 Push into an empty FIFO on a boundary edge SHALL NOT be popped that edge; that case counts as an underrun.
REQ-028 Pointers SHALL wrap modulo DEPTH; fill SHALL never exceed DEPTH or go below 0.
REQ-029 Changing mute mid-frame SHALL take effect at the next frame boundary only.

Reset
REQ-030 While Reset=1, and immediately on its assertion (including mid-frame): cnt=0, ws=0, data_left=data_right=0, frame_strobe=0, FIFO empty (fill=0, in_ready=1), underruns=0.
REQ-031 After Reset deasserts, the first frame boundary SHALL occur FRAME_CYCLES edges later.

Structure
REQ-032 Package audio_pkg SHALL hold AUDIO_SIZE (8), FRAME_CYCLES_48K (1042), FIFO_DEPTH (4), and typedef stereo_sample_t {left, right}.
REQ-033 The FIFO SHALL be a separate sub-module, sample_fifo (push/pop/full/empty/count), instantiated once.

Verification (bench uses FRAME_CYCLES=8, DEPTH=4, SIZE=8)
REQ-034 Reset, then idle 8 cycles -> ws=0 for cnt 0..3 and 1 for cnt 4..7; frame_strobe at cnt==0; data 0; underruns=1 after the first boundary.
REQ-035 Push (0x11,0x22),(0x33,0x44) before a boundary -> next two frames output 0x11/0x22 then 0x33/0x44; fill goes 2, 1, 0.
REQ-036 Hold in_valid with 5 frames between boundaries -> in_ready=0 at fill=4; the 5th frame is accepted only after the next pop; output order is preserved.
REQ-037 Set mute=1 with (0x7F,0x80) queued -> outputs 0 for that frame and fill decrements; after mute=0, the next queued frame appears.
REQ-038 Assert Reset mid-frame with fill=3 -> all outputs return to reset values at once; queued data is lost; no output glitches afterwards.
REQ-039 Run 300 empty frames -> underruns saturates at 255 and does not wrap.
